// File: rtl/fetch_stage.sv
// WISC-S15 instruction-fetch stage with IF/ID register, imem req/ack handshake, redirect flush and HALT stop.
// Optional perf counters (perf_fetch, perf_bubble) are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INSTR  = 16'hF000,
  parameter logic [15:0] HALT_INSTR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc1,
  output logic        if_id_valid,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] perf_fetch,
  output logic [15:0] perf_bubble
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_DRAIN,
    S_HOLD,
    S_HALTED
  } state_t;

  state_t      state;
  state_t      state_d;
  logic [15:0] pc;
  logic [15:0] pc_d;
  logic [15:0] pc_inc;
  logic [15:0] drain_addr;
  logic [15:0] drain_addr_d;
  logic [15:0] hold_buf;
  logic [15:0] hold_buf_d;
  logic [15:0] fetch_word;
  logic        load_fetch;
  logic        load_bubble;

  assign pc_inc = pc + 16'd1;

  // While draining a squashed request the bus must keep showing the old address, not the new pc.
  assign imem_req  = (state == S_REQ) || (state == S_DRAIN);
  assign imem_addr = (state == S_DRAIN) ? drain_addr : pc;
  assign halted    = (state == S_HALTED);

  always_comb begin
    state_d      = state;
    pc_d         = pc;
    drain_addr_d = drain_addr;
    hold_buf_d   = hold_buf;
    fetch_word   = imem_rdata;
    load_fetch   = 1'b0;
    load_bubble  = 1'b0;

    case (state)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect) begin
          pc_d        = redirect_pc;
          load_bubble = 1'b1;
        end else if (!stall) begin
          load_bubble = 1'b1;
        end
      end

      S_REQ: begin
        if (redirect) begin
          pc_d        = redirect_pc;
          load_bubble = 1'b1;
          if (!imem_ack) begin
            drain_addr_d = pc;
            state_d      = S_DRAIN;
          end
        end else if (imem_ack && stall) begin
          hold_buf_d = imem_rdata;
          state_d    = S_HOLD;
        end else if (imem_ack) begin
          load_fetch = 1'b1;
          state_d    = (imem_rdata == HALT_INSTR) ? S_HALTED : S_REQ;
        end else if (!stall) begin
          load_bubble = 1'b1;
        end
      end

      S_DRAIN: begin
        if (redirect) begin
          pc_d        = redirect_pc;
          load_bubble = 1'b1;
        end else if (!stall) begin
          load_bubble = 1'b1;
        end
        if (imem_ack) begin
          state_d = S_REQ;
        end
      end

      S_HOLD: begin
        fetch_word = hold_buf;
        if (redirect) begin
          pc_d        = redirect_pc;
          load_bubble = 1'b1;
          hold_buf_d  = '0;
          state_d     = S_REQ;
        end else if (!stall) begin
          load_fetch = 1'b1;
          hold_buf_d = '0;
          state_d    = (hold_buf == HALT_INSTR) ? S_HALTED : S_REQ;
        end
      end

      S_HALTED: begin
        if (redirect) begin
          pc_d        = redirect_pc;
          load_bubble = 1'b1;
          state_d     = S_REQ;
        end else if (!stall) begin
          load_bubble = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load_fetch) begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      drain_addr  <= RESET_PC;
      hold_buf    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_pc1   <= '0;
      if_id_valid <= 1'b0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      drain_addr <= drain_addr_d;
      hold_buf   <= hold_buf_d;
      // pc_inc is the link value of the word being loaded, since pc still points at it this cycle.
      if (load_fetch) begin
        if_id_instr <= fetch_word;
        if_id_pc1   <= pc_inc;
        if_id_valid <= 1'b1;
      end else if (load_bubble) begin
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch  <= '0;
      perf_bubble <= '0;
    end else if (!halted) begin
      if (load_fetch && (perf_fetch != 16'hFFFF)) begin
        perf_fetch <= perf_fetch + 16'd1;
      end
      if (load_bubble && (perf_bubble != 16'hFFFF)) begin
        perf_bubble <= perf_bubble + 16'd1;
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: random stall/redirect/ack timing against a transaction-level fetch model.
module tb_fetch_stage;

  localparam logic [15:0] NOP    = 16'hF000;
  localparam logic [15:0] HALT   = 16'hFFFF;
  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc1;
  logic        if_id_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetch;
  logic [15:0] perf_bubble;
`endif

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_id_instr (if_id_instr),
    .if_id_pc1   (if_id_pc1),
    .if_id_valid (if_id_valid),
    .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch  (perf_fetch),
    .perf_bubble (perf_bubble)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];
  int n_compared = 0;
  int n_mismatched = 0;

  // Model: architectural next-fetch pc, expected IF/ID contents, parked word, wrong-path request flag.
  logic [15:0] m_instr, m_pc1, m_pc, m_buf;
  logic        m_valid, m_halted, m_buffered, m_squash;
  logic        prev_req, prev_ack;
  logic [15:0] prev_addr;
  int          req_age, gap;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_instr = NOP; m_pc1 = '0; m_valid = 1'b0; m_pc = RST_PC; m_buf = '0;
    m_halted = 1'b0; m_buffered = 1'b0; m_squash = 1'b0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0; req_age = 0; gap = 0;
  endtask

  task automatic deliver(input logic [15:0] w);
    m_instr = w;
    m_pc1   = m_pc + 16'd1;
    m_valid = 1'b1;
    m_pc    = m_pc + 16'd1;
    if (w == HALT) m_halted = 1'b1;
  endtask

  // Entered at a negedge: check outputs, act as memory, drive inputs, advance model, wait one cycle.
  task automatic applyStimulus(input bit st, input bit rd, input logic [15:0] rpc,
                               input int ack_pct, input bit stale);
    bit          new_req, ack, accepted;
    logic [15:0] rdata;
    checkOutput("if_id_valid", if_id_valid, m_valid);
    checkOutput("if_id_instr", if_id_instr, m_instr);
    if (m_valid) checkOutput("if_id_pc1", if_id_pc1, m_pc1);
    checkOutput("halted", halted, m_halted);
    if (m_halted || m_buffered) begin
      checkOutput("req_while_parked", imem_req, 0);
      gap = 0;
    end else if (!imem_req) begin
      gap++;
      checkOutput("req_gap", gap > 1, 0);
    end else begin
      gap = 0;
    end
    new_req = imem_req && !(prev_req && !prev_ack);
    if (imem_req && !new_req) checkOutput("addr_stable", imem_addr, prev_addr);
    if (new_req) checkOutput("req_addr", imem_addr, m_pc);
    if (new_req) req_age = 0;
    else if (imem_req) req_age++;

    ack = 1'b0;
    rdata = 16'($urandom);
    if (imem_req && req_age >= 1 && ($urandom_range(99) < ack_pct)) begin
      ack = 1'b1;
      rdata = mem[imem_addr];
    end else if (stale && !imem_req) begin
      ack = 1'b1;
      rdata = 16'hDEAD;
    end
    stall = st; redirect = rd; redirect_pc = rpc; imem_ack = ack; imem_rdata = rdata;

    if (rd) begin
      if (imem_req) m_squash = !ack;
      m_buffered = 1'b0; m_halted = 1'b0; m_pc = rpc;
      m_instr = NOP; m_valid = 1'b0;
    end else begin
      accepted = imem_req && ack && !m_squash;
      if (imem_req && ack) m_squash = 1'b0;
      if (st) begin
        if (accepted) begin
          m_buffered = 1'b1;
          m_buf = rdata;
        end
      end else if (m_buffered) begin
        m_buffered = 1'b0;
        deliver(m_buf);
      end else if (accepted) begin
        deliver(rdata);
      end else begin
        m_instr = NOP;
        m_valid = 1'b0;
      end
    end
    prev_req = imem_req; prev_ack = ack; prev_addr = imem_addr;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'($urandom);
      if (mem[i] == HALT) mem[i] = 16'h0123;
      if (i[5:0] == 6'h2A) mem[i] = HALT;
    end
    mem[16'h0000] = 16'h1234;
    mem[16'h0001] = 16'h2345;
    mem[16'h0005] = 16'h5678;
    mem[16'h0042] = HALT;
    mem[16'hFFFE] = 16'hABCD;
    mem[16'hFFFF] = 16'h1111;

    modelReset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back fetch from reset, memory acking as early as allowed.
    repeat (8) applyStimulus(0, 0, 16'h0, 100, 0);
    // Stall across an ack, then release.
    repeat (4) applyStimulus(1, 0, 16'h0, 100, 0);
    repeat (4) applyStimulus(0, 0, 16'h0, 100, 0);
    // Redirect while a request is outstanding; runs into the HALT at 0x0042.
    applyStimulus(0, 0, 16'h0, 0, 0);
    applyStimulus(0, 1, 16'h0040, 0, 0);
    repeat (2) applyStimulus(0, 0, 16'h0, 0, 0);
    repeat (10) applyStimulus(0, 0, 16'h0, 100, 0);
    applyStimulus(1, 0, 16'h0, 100, 0);
    repeat (3) applyStimulus(0, 0, 16'h0, 100, 0);
    applyStimulus(0, 1, 16'h0010, 100, 0);
    repeat (6) applyStimulus(0, 0, 16'h0, 100, 0);
    // PC wrap from 0xFFFF to 0x0000.
    applyStimulus(0, 1, 16'hFFFE, 100, 0);
    repeat (8) applyStimulus(0, 0, 16'h0, 100, 0);

    repeat (3000) begin
      bit          st, rd;
      logic [15:0] rpc;
      st  = ($urandom_range(99) < 25);
      rd  = ($urandom_range(99) < 4);
      rpc = ($urandom_range(1) == 1) ? 16'($urandom) : 16'($urandom_range(16'h0070, 16'h0020));
      applyStimulus(st, rd, rpc, 50, 0);
    end

    // Async reset in the middle of an outstanding request.
    applyStimulus(0, 1, 16'h0100, 0, 0);
    checkOutput("pre_rst_req", imem_req, 1);
    applyStimulus(0, 0, 16'h0, 0, 0);
    stall = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_imem_req", imem_req, 0);
    checkOutput("rst_imem_addr", imem_addr, RST_PC);
    checkOutput("rst_instr", if_id_instr, NOP);
    checkOutput("rst_pc1", if_id_pc1, 0);
    checkOutput("rst_valid", if_id_valid, 0);
    checkOutput("rst_halted", halted, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    applyStimulus(0, 0, 16'h0, 100, 1);
    repeat (10) applyStimulus(0, 0, 16'h0, 100, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
